execute_unit: RTL and testbench

EXECUTE_UNIT -- requirements
Module: execute_unit

---
 rtl/execute_unit_pkg.sv | 34 +++
 rtl/execute_unit_shifter_iter.sv | 30 +++
 rtl/execute_unit.sv | 136 +++++++++++++
 tb/tb_execute_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/execute_unit_pkg.sv
// Shared opcode and FSM encodings for the execute stage and its decoder.
package execute_unit_pkg;

    localparam int XLEN   = 32;
    localparam int OP_W   = 4;
    localparam int SHAM_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOR = 4'd5,
        OP_SLT = 4'd6,
        OP_SLL = 4'd7,
        OP_SRL = 4'd8,
        OP_SRA = 4'd9
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return op <= OP_SRA;
    endfunction

endpackage

// File: rtl/execute_unit_shifter_iter.sv
// One-bit-per-cycle shifter; a load may take its first step in the same cycle.
module shifter_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             shift_left,
    input  logic             arith,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] shifted;

    assign src = load ? load_value : value;

    always_comb begin
        if (shift_left) shifted = {src[WIDTH-2:0], 1'b0};
        else            shifted = {arith & src[WIDTH-1], src[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               value <= '0;
        else if (load || step)  value <= step ? shifted : src;
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU ops and iterative shifts, writing back to the register file.
module execute_unit
    import execute_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [WIDTH-1:0]  rs_data,
    input  logic [WIDTH-1:0]  rt_data,
    input  logic [SHAM_W-1:0] shamt,
    input  logic [4:0]        rd_addr,
    output logic              wb_we,
    output logic [4:0]        wb_addr,
    output logic [WIDTH-1:0]  wb_data,
    output logic              busy,
    output logic              ovf
);

    state_e              state, state_next;
    logic [SHAM_W-1:0]   shift_cnt;
    logic [4:0]          shift_rd;
    logic                shift_left_q, shift_arith_q;
    logic                accept, start_shift, shift_last;
    logic                sh_step, sh_left, sh_arith;
    logic [WIDTH-1:0]    sh_value;
    logic [WIDTH-1:0]    sum, diff, alu_result;
    logic                slt, alu_ovf;

    assign accept      = in_valid && in_ready;
    assign start_shift = accept && is_shift(op) && (shamt != '0);
    assign shift_last  = (state == ST_SHIFT) && (shift_cnt == SHAM_W'(1));

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_shift) state_next = ST_SHIFT;
            ST_SHIFT: if (shift_last)  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE);
        busy     = (state == ST_SHIFT);
    end

    assign sum  = rs_data + rt_data;
    assign diff = rs_data - rt_data;
    assign slt  = $signed(rs_data) < $signed(rt_data);

    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_result = sum;
                alu_ovf    = (rs_data[WIDTH-1] == rt_data[WIDTH-1]) && (sum[WIDTH-1] != rs_data[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = diff;
                alu_ovf    = (rs_data[WIDTH-1] != rt_data[WIDTH-1]) && (diff[WIDTH-1] != rs_data[WIDTH-1]);
            end
            OP_AND:                 alu_result = rs_data & rt_data;
            OP_OR:                  alu_result = rs_data | rt_data;
            OP_XOR:                 alu_result = rs_data ^ rt_data;
            OP_NOR:                 alu_result = ~(rs_data | rt_data);
            OP_SLT:                 alu_result = {{(WIDTH-1){1'b0}}, slt};
            OP_SLL, OP_SRL, OP_SRA: alu_result = rt_data;
            default:                alu_result = '0;
        endcase
    end

    // The first shift step happens on the load edge, so the final value is ready when the count hits 1.
    assign sh_step  = start_shift || ((state == ST_SHIFT) && !shift_last);
    assign sh_left  = (state == ST_IDLE) ? (op == OP_SLL) : shift_left_q;
    assign sh_arith = (state == ST_IDLE) ? (op == OP_SRA) : shift_arith_q;

    shifter_iter #(.WIDTH(WIDTH)) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (start_shift),
        .step       (sh_step),
        .shift_left (sh_left),
        .arith      (sh_arith),
        .load_value (rt_data),
        .value      (sh_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_we         <= 1'b0;
            ovf           <= 1'b0;
            wb_addr       <= '0;
            wb_data       <= '0;
            shift_cnt     <= '0;
            shift_rd      <= '0;
            shift_left_q  <= 1'b0;
            shift_arith_q <= 1'b0;
        end else begin
            wb_we <= 1'b0;
            ovf   <= 1'b0;
            if (state == ST_SHIFT) begin
                shift_cnt <= shift_cnt - SHAM_W'(1);
                if (shift_last && (shift_rd != '0)) begin
                    wb_we   <= 1'b1;
                    wb_addr <= shift_rd;
                    wb_data <= sh_value;
                end
            end else if (start_shift) begin
                shift_cnt     <= shamt;
                shift_rd      <= rd_addr;
                shift_left_q  <= (op == OP_SLL);
                shift_arith_q <= (op == OP_SRA);
            end else if (accept && is_legal(op)) begin
                ovf <= alu_ovf;
                if ((rd_addr != '0) && !alu_ovf) begin
                    wb_we   <= 1'b1;
                    wb_addr <= rd_addr;
                    wb_data <= alu_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: driver predicts write-backs, monitor matches them per cycle.
module tb_execute_unit;
    import execute_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [4:0]  shamt = '0;
    logic [4:0]  rd_addr = '0;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic        ovf;

    execute_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .shamt    (shamt),
        .rd_addr  (rd_addr),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_no;
        bit          we;
        bit          ovf;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          busy_from = 0;
    int          busy_until = 0;
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Reference model: plain arithmetic on the operands, expected output keyed by cycle.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, input logic [4:0] d);
        exp_t        e;
        int          acc;
        longint      sx;
        logic [31:0] res;
        bit          ov, legal, is_sh;
        in_valid = 1'b1; op = o; rs_data = a; rt_data = b; shamt = s; rd_addr = d;
        while (cyc < busy_until) @(negedge clk);
        acc   = cyc + 1;
        legal = (o <= 4'd9);
        is_sh = (o >= 4'd7) && (o <= 4'd9) && (s != 0);
        ov    = 1'b0;
        res   = '0;
        sx    = 0;
        case (o)
            4'd0: begin sx = longint'($signed(a)) + longint'($signed(b)); res = sx[31:0]; ov = (sx > MAX_S) || (sx < MIN_S); end
            4'd1: begin sx = longint'($signed(a)) - longint'($signed(b)); res = sx[31:0]; ov = (sx > MAX_S) || (sx < MIN_S); end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = ~(a | b);
            4'd6: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7: res = b << s;
            4'd8: res = b >> s;
            4'd9: res = $signed(b) >>> s;
            default: res = '0;
        endcase
        if (is_sh) begin
            busy_from  = acc;
            busy_until = acc + int'(s);
        end
        e.edge_no = acc + (is_sh ? int'(s) : 0);
        e.we      = legal && (d != 0) && !ov;
        e.ovf     = ov;
        e.addr    = d;
        e.data    = res;
        if (e.we || e.ovf) sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].edge_no < cyc) begin
                mon_e = sb.pop_front();
                check("late_writeback", 32'd0, 32'd1);
            end
            if (wb_we || ovf) begin
                if (sb.size() > 0 && sb[0].edge_no == cyc) begin
                    mon_e = sb.pop_front();
                    check("wb_we", wb_we, mon_e.we);
                    check("ovf", ovf, mon_e.ovf);
                    if (mon_e.we) begin
                        last_addr = mon_e.addr;
                        last_data = mon_e.data;
                    end
                end else begin
                    check("unexpected_output", 32'd1, 32'd0);
                end
            end else if (sb.size() > 0 && sb[0].edge_no == cyc) begin
                mon_e = sb.pop_front();
                check("missing_output", 32'd0, 32'd1);
                if (mon_e.we) begin
                    last_addr = mon_e.addr;
                    last_data = mon_e.data;
                end
            end
            check("wb_addr", wb_addr, last_addr);
            check("wb_data", wb_data, last_data);
            check("in_ready", in_ready, !(cyc >= busy_from && cyc < busy_until));
            check("busy", busy, (cyc >= busy_from && cyc < busy_until));
        end
    end

    initial begin
        logic [31:0] a, b;
        #1 rst = 1'b0;
        idle(3);
        check("rst_in_ready", in_ready, 1);
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_data", wb_data, 0);
        rst = 1'b1;

        issue(OP_ADD, 32'd5, 32'd7, 5'd0, 5'd3);
        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd4);
        issue(OP_SUB, 32'h8000_0000, 32'd1, 5'd0, 5'd4);
        idle(1);
        issue(OP_SRA, 32'd0, 32'h8000_0010, 5'd4, 5'd9);
        issue(OP_AND, 32'hF0F0_1234, 32'hFF00_FF00, 5'd0, 5'd1);
        issue(OP_OR,  32'h0F0F_0000, 32'h0000_00F0, 5'd0, 5'd2);
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd6);
        issue(OP_OR,  32'h1234_5678, 32'h1, 5'd0, 5'd0);
        issue(4'd12,  32'h1, 32'h2, 5'd3, 5'd8);
        issue(OP_ADD, 32'h8000_0000, 32'h8000_0000, 5'd0, 5'd0);
        issue(OP_SLL, 32'd0, 32'hDEAD_BEEF, 5'd0, 5'd10);
        issue(OP_SRL, 32'd0, 32'h8000_0001, 5'd1, 5'd11);
        issue(OP_SLL, 32'd0, 32'h0000_0003, 5'd31, 5'd12);
        issue(OP_NOR, 32'h0, 32'h0, 5'd0, 5'd13);
        issue(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 5'd14);
        idle(2);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'h7FFF_FFFF;
                1:       a = 32'h8000_0000;
                2:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            issue(4'($urandom_range(0, 15)), a, b, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(40);

        issue(OP_SLL, 32'd0, 32'h0000_0001, 5'd31, 5'd7);
        idle(9);
        #2 rst = 1'b0;
        #1;
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_wb_we", wb_we, 0);
        check("async_rst_ovf", ovf, 0);
        check("async_rst_wb_addr", wb_addr, 0);
        check("async_rst_wb_data", wb_data, 0);
        sb.delete();
        busy_from  = 0;
        busy_until = 0;
        last_addr  = '0;
        last_data  = '0;
        idle(2);
        rst = 1'b1;
        issue(OP_ADD, 32'd1, 32'd1, 5'd0, 5'd5);
        idle(40);

        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
